// File: rtl/bram_pixel_streamer_if.sv
// BRAM read port plus the pixel stream leaving the streamer.
interface bram_pixel_streamer_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24
);
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [11:0]       m_x;
  logic [11:0]       m_y;
  logic              m_sof;
  logic              m_eol;
  logic              m_eof;

  modport master (
    output bram_en, bram_addr, m_valid, m_data, m_x, m_y, m_sof, m_eol, m_eof,
    input  bram_dout, m_ready
  );

  modport slave (
    input  bram_en, bram_addr, m_valid, m_data, m_x, m_y, m_sof, m_eol, m_eof,
    output bram_dout, m_ready
  );
endinterface

// File: rtl/bram_pixel_streamer.sv
// Streams one stored frame out of the image BRAM in raster order.
// Reads are credit-limited so that everything in flight always fits in the
// output FIFO; x/y and frame/line markers are derived on the pop side.
module bram_pixel_streamer #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24,
  parameter int IMG_W  = 500,
  parameter int IMG_H  = 400,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic clka,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  bram_pixel_streamer_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_D);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [11:0] LAST_X = 12'(IMG_W - 1);
  localparam logic [11:0] LAST_Y = 12'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [DATA_W-1:0] mem_q [FIFO_D];
  logic [DATA_W-1:0] mem_d [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [11:0]       x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]  inflight;
  logic              credit, issue, fifo_wr, pop;

  // Reads issued but not yet landed in the FIFO still hold a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(vld_pipe_q[i]);
  end

  assign credit  = (inflight + fifo_cnt_q) < CNT_W'(FIFO_D);
  assign fifo_wr = vld_pipe_q[RD_LAT-1];
  assign pop     = bus.m_valid & bus.m_ready;

  // Frame sequencing: issue reads while credit lasts, then drain the FIFO.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        addr_d  = '0;
      end
      READ: if (credit) begin
        issue  = 1'b1;
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == LAST_ADDR) state_d = DRAIN;
      end
      // Leave on the cycle the last beat pops so done follows it directly.
      DRAIN: if (inflight == '0 &&
                 (fifo_cnt_q == '0 || (fifo_cnt_q == CNT_W'(1) && pop)))
        state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read-latency tracker and FIFO bookkeeping.
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    vld_pipe_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    mem_d = mem_q;
    if (fifo_wr) mem_d[wr_ptr_q] = bus.bram_dout;
    wr_ptr_d   = fifo_wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_wr) - CNT_W'(pop);
  end

  // Coordinates advance per accepted beat, not per read.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (state_q == DONE) begin
      x_d = '0;
      y_d = '0;
    end else if (pop) begin
      if (x_q == LAST_X) begin
        x_d = '0;
        y_d = (y_q == LAST_Y) ? '0 : y_q + 12'd1;
      end else begin
        x_d = x_q + 12'd1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      vld_pipe_q <= '0;
      for (int i = 0; i < FIFO_D; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      vld_pipe_q <= vld_pipe_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign busy          = (state_q == READ) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign bus.bram_en   = issue;
  assign bus.bram_addr = addr_q;
  assign bus.m_valid   = (fifo_cnt_q != '0);
  assign bus.m_data    = bus.m_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.m_x       = x_q;
  assign bus.m_y       = y_q;
  assign bus.m_sof     = bus.m_valid && x_q == '0 && y_q == '0;
  assign bus.m_eol     = bus.m_valid && x_q == LAST_X;
  assign bus.m_eof     = bus.m_valid && x_q == LAST_X && y_q == LAST_Y;
endmodule

// File: tb/tb_bram_pixel_streamer.sv
// Three streamers share start/ready: 4x3 RD_LAT=1, 4x3 RD_LAT=2, 1x1 RD_LAT=1.
module tb_bram_pixel_streamer;
  logic clk = 1'b0;
  logic rst_n, start, rdy;
  int   cyc = 0;
  int   n_chk = 0, n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 2) ? 1 : 4;
    localparam int H = (g == 2) ? 1 : 3;
    localparam int L = (g == 1) ? 2 : 1;
    localparam int N = W * H;

    bram_pixel_streamer_if #(.ADDR_W(18), .DATA_W(24)) bus ();
    logic busy, done;

    bram_pixel_streamer #(.ADDR_W(18), .DATA_W(24), .IMG_W(W), .IMG_H(H),
                          .RD_LAT(L), .FIFO_D(4)) dut (
      .clka(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .bus(bus));

    // BRAM model: dout = address, L cycles after the enabled read.
    logic [17:0] a_pipe [2];
    always @(posedge clk) begin
      if (bus.bram_en) a_pipe[0] <= bus.bram_addr;
      a_pipe[1] <= a_pipe[0];
    end
    assign bus.bram_dout = {6'b0, a_pipe[L-1]};
    assign bus.m_ready   = rdy;

    logic [63:0] obs_w;
    logic [84:0] allout;
    assign obs_w  = {12'b0, bus.m_valid, bus.m_sof, bus.m_eol, bus.m_eof,
                     bus.m_data, bus.m_x, bus.m_y};
    assign allout = {busy, done, bus.bram_en, bus.bram_addr, obs_w};

    int exp_i = 0, iss_i = 0, outst = 0;
    int beats = 0, dones = 0, issued = 0;
    int sof_n = 0, eol_n = 0, eof_n = 0;
    int start_c = 0, first_en_c = -1, first_v_c = -1, last_c = 0, done_c = 0;
    logic [23:0] xy5 = '0, first_d = '1;
    logic        got_first = 1'b0, stall_p = 1'b0;
    logic [63:0] snap_p = '0, exp_w;

    always @(negedge clk) begin
      if (!rst_n) begin
        exp_i = 0; iss_i = 0; outst = 0; stall_p = 1'b0;
      end else begin
        if (start) begin
          start_c = cyc; first_en_c = -1; first_v_c = -1;
          sof_n = 0; eol_n = 0; eof_n = 0; got_first = 1'b0;
        end
        if (stall_p) chk("stall_hold", 128'(obs_w), 128'(snap_p));
        if (bus.bram_en) begin
          issued++; outst++;
          if (first_en_c < 0) first_en_c = cyc;
          chk("rd_addr", 128'(bus.bram_addr), 128'(iss_i));
          chk("credit", 128'(outst > 4), 128'(0));
          iss_i = (iss_i == N - 1) ? 0 : iss_i + 1;
        end
        if (bus.m_valid && first_v_c < 0) first_v_c = cyc;
        if (bus.m_valid && rdy) begin
          exp_w = {12'b0, 1'b1, exp_i == 0, (exp_i % W) == W - 1, exp_i == N - 1,
                   6'b0, 18'(exp_i), 12'(exp_i % W), 12'(exp_i / W)};
          chk("beat", 128'(obs_w), 128'(exp_w));
          if (!got_first) begin first_d = bus.m_data; got_first = 1'b1; end
          if (bus.m_sof) sof_n++;
          if (bus.m_eol) eol_n++;
          if (bus.m_eof) eof_n++;
          if (exp_i == 5) xy5 = {bus.m_x, bus.m_y};
          if (exp_i == N - 1) last_c = cyc;
          exp_i = (exp_i == N - 1) ? 0 : exp_i + 1;
          beats++; outst--;
        end
        if (done) begin dones++; done_c = cyc; end
        stall_p = bus.m_valid && !rdy;
        snap_p  = obs_w;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Bounded wait for both 4x3 streamers to reach the given done counts.
  task automatic wait_frames(input int t0, input int t1, input int rand_rdy);
    int n = 0;
    while ((g_dut[0].dones < t0 || g_dut[1].dones < t1) && n < 1000) begin
      if (rand_rdy != 0) rdy = ($urandom_range(0, 9) < 3);
      tick(1);
      n++;
    end
    chk("frame_timeout", 128'(n >= 1000), 128'(0));
    rdy = 1'b1;
  endtask

  int d0, d1, b0, b1, i0, i1, n;

  initial begin
    rst_n = 1'b0; start = 1'b0; rdy = 1'b1;
    tick(3);
    @(negedge clk);
    chk("reset_out0", 128'(g_dut[0].allout), 128'(0));
    chk("reset_out1", 128'(g_dut[1].allout), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);

    // Full-rate frame: latency, no bubbles, markers, done timing.
    d0 = g_dut[0].dones; d1 = g_dut[1].dones; b0 = g_dut[0].beats;
    pulse_start();
    wait_frames(d0 + 1, d1 + 1, 0);
    tick(3);
    chk("en_lat0", 128'(g_dut[0].first_en_c - g_dut[0].start_c), 128'(1));
    chk("en_lat1", 128'(g_dut[1].first_en_c - g_dut[1].start_c), 128'(1));
    chk("v_lat0",  128'(g_dut[0].first_v_c - g_dut[0].first_en_c), 128'(2));
    chk("v_lat1",  128'(g_dut[1].first_v_c - g_dut[1].first_en_c), 128'(3));
    chk("nogap0",  128'(g_dut[0].last_c - g_dut[0].first_v_c), 128'(11));
    chk("nogap1",  128'(g_dut[1].last_c - g_dut[1].first_v_c), 128'(11));
    chk("done_lat0", 128'(g_dut[0].done_c - g_dut[0].last_c), 128'(1));
    chk("done_lat1", 128'(g_dut[1].done_c - g_dut[1].last_c), 128'(1));
    chk("beats0", 128'(g_dut[0].beats - b0), 128'(12));
    chk("sof_n",  128'(g_dut[0].sof_n), 128'(1));
    chk("eol_n",  128'(g_dut[0].eol_n), 128'(3));
    chk("eof_n",  128'(g_dut[0].eof_n), 128'(1));
    chk("xy_beat5", 128'(g_dut[0].xy5), 128'({12'd1, 12'd1}));
    chk("one_px_marks", 128'({g_dut[2].sof_n[1:0], g_dut[2].eol_n[1:0], g_dut[2].eof_n[1:0]}),
        128'(6'b01_01_01));
    chk("one_px_done", 128'(g_dut[2].dones), 128'(1));

    // Backpressure at start: exactly FIFO_D reads, then nothing.
    i0 = g_dut[0].issued; i1 = g_dut[1].issued;
    d0 = g_dut[0].dones; d1 = g_dut[1].dones;
    rdy = 1'b0;
    pulse_start();
    tick(19);
    chk("stall_reads0", 128'(g_dut[0].issued - i0), 128'(4));
    chk("stall_reads1", 128'(g_dut[1].issued - i1), 128'(4));
    rdy = 1'b1;
    wait_frames(d0 + 1, d1 + 1, 0);
    chk("frame_reads0", 128'(g_dut[0].issued - i0), 128'(12));

    // Random 30% ready over three frames.
    for (int f = 0; f < 3; f++) begin
      d0 = g_dut[0].dones; d1 = g_dut[1].dones;
      b0 = g_dut[0].beats; b1 = g_dut[1].beats;
      pulse_start();
      wait_frames(d0 + 1, d1 + 1, 1);
      tick(2);
      chk("rand_beats0", 128'(g_dut[0].beats - b0), 128'(12));
      chk("rand_beats1", 128'(g_dut[1].beats - b1), 128'(12));
    end

    // Start mid-frame is ignored.
    d0 = g_dut[0].dones; d1 = g_dut[1].dones;
    b0 = g_dut[0].beats; b1 = g_dut[1].beats;
    pulse_start();
    n = 0;
    while (g_dut[0].exp_i != 5 && n < 100) begin tick(1); n++; end
    chk("mid_timeout", 128'(n >= 100), 128'(0));
    pulse_start();
    wait_frames(d0 + 1, d1 + 1, 0);
    tick(10);
    chk("mid_dones0", 128'(g_dut[0].dones - d0), 128'(1));
    chk("mid_dones1", 128'(g_dut[1].dones - d1), 128'(1));
    chk("mid_beats0", 128'(g_dut[0].beats - b0), 128'(12));
    chk("mid_beats1", 128'(g_dut[1].beats - b1), 128'(12));

    // Reset mid-frame, then a fresh frame from address 0.
    d0 = g_dut[0].dones;
    pulse_start();
    n = 0;
    while (g_dut[0].exp_i != 6 && n < 100) begin tick(1); n++; end
    chk("rst_timeout", 128'(n >= 100), 128'(0));
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out0", 128'(g_dut[0].allout), 128'(0));
    chk("midrst_out1", 128'(g_dut[1].allout), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);
    chk("rst_no_done", 128'(g_dut[0].dones - d0), 128'(0));
    d0 = g_dut[0].dones; d1 = g_dut[1].dones;
    b0 = g_dut[0].beats;
    pulse_start();
    wait_frames(d0 + 1, d1 + 1, 0);
    tick(2);
    chk("rst_first0", 128'(g_dut[0].first_d), 128'(0));
    chk("rst_first1", 128'(g_dut[1].first_d), 128'(0));
    chk("rst_beats0", 128'(g_dut[0].beats - b0), 128'(12));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
